seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive matching samples needed before a pattern is accepted (legal range 1..15).
REQ-002 Clock  input  1  system clock; every register updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 SEG0  input  7  active-low segment pattern for the low digit, bit0 = segment a ... bit6 = segment g; synchronous to Clock.
REQ-005 SEG1  input  7  active-low segment pattern for the high digit, same bit order as SEG0.
REQ-006 Ack  input  1  consumer acknowledge; a 1-cycle or longer pulse is permitted.
REQ-007 Q  output  8  decoded value: Q[7:4] from SEG1, Q[3:0] from SEG0.
REQ-008 Valid  output  1  Q, Err and Overrun hold a presented result.
REQ-009 Err  output  1  at least one digit of the presented pattern is illegal.
REQ-010 Overrun  output  1  a different stable pattern was missed while Valid was high.

Function
REQ-011 Decode table, per digit (hex value of the 7-bit pattern -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F (blank)->F.
REQ-012 Any pattern outside REQ-011 decodes to nibble E and sets Err for that result.
REQ-013 Sampler: a 14-bit shadow register and a count register run continuously, independent of FSM state.
REQ-014 On each edge where {SEG1,SEG0} differs from shadow, the shadow loads the input and count clears to 0.
REQ-015 On each edge where the input equals shadow, count increments and saturates at STABLE_CYCLES.
REQ-016 A shadow is stable when count equals STABLE_CYCLES.
REQ-017 FSM states: WAIT and PRESENT; WAIT is the reset state.
REQ-018 WAIT to PRESENT: the shadow is stable and it differs from the last-reported pattern, or no pattern has been reported since reset.
REQ-019 On that transition edge, Q and Err load from the decoded shadow, Valid goes to 1, the last-reported register loads the shadow, and the first-report flag clears.
REQ-020 Latency: if the input changes before edge 0 and then holds, Valid is 1 after edge STABLE_CYCLES, i.e. edge 4 by default.
REQ-021 PRESENT: Q, Err and Valid stay frozen; input activity does not alter them.
REQ-022 PRESENT to WAIT: on the edge where Ack=1, Valid, Err and Overrun clear to 0, and Q holds its last value.
REQ-023 In PRESENT, a stable shadow that differs from the last-reported pattern sets Overrun to 1; Overrun is sticky until the Ack edge.
REQ-024 Ack sampled in WAIT is ignored.
REQ-025 A pattern equal to the last-reported one is never re-presented, even if it bounces and re-stabilizes.
REQ-026 After an Ack, a stable shadow that differs from last-reported is presented on the next edge; the sampler count is not restarted.
REQ-027 If the stable-and-new condition coincides with the Ack edge, the FSM enters WAIT first, and presentation occurs on the following edge.

Reset
REQ-028 While Reset=1: Q=00, Valid=0, Err=0, Overrun=0, state=WAIT, shadow=0, count=0, last-reported=0, first-report flag=1.
REQ-029 Reset asserted mid-PRESENT or mid-count aborts immediately.
REQ-030 After Reset releases, the next report requires a full STABLE_CYCLES stable period, measured from the first edge after release.

Verification
REQ-031 Hold SEG1=30, SEG0=02 from reset release -> Valid=1 after edge 4, Q=36, Err=0; Q stays 36 until Ack; Valid=0 after the Ack edge.
REQ-032 Toggle SEG0 between 40 and 79 every 2 cycles with STABLE_CYCLES=4 -> Valid never asserts; then hold 79 -> Valid=1 four edges later, Q[3:0]=1.
REQ-033 SEG1=7F, SEG0=55 held -> Q=FE, Err=1, Valid=1.
REQ-034 While Valid=1 with Q=36, change input to 00/00 and hold for 6 cycles -> Overrun=1 and Q still 36; on Ack, Valid drops; next edge Valid=1 with Q=88 and Overrun=0.
REQ-035 After Ack, keep the same pattern and apply a 1-cycle glitch -> no new Valid.
REQ-036 Assert Reset for 1 cycle while Valid=1 -> all outputs 0 immediately; the held pattern is re-presented STABLE_CYCLES edges after release.

Source files
------------

// File: rtl/seg7_reader.sv
// ============================================================================
// Module   : seg7_reader
// Purpose  : Debounces a pair of active-low 7-segment patterns and presents
//            each newly stable, decoded byte with a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic       ack,
  output logic [7:0] q,
  output logic       valid,
  output logic       err,
  output logic       overrun
);

  localparam int unsigned     c_cw     = 4;
  localparam logic [c_cw-1:0] c_stable = c_cw'(STABLE_CYCLES);

  localparam logic [0:0] c_st_wait    = 1'b0;
  localparam logic [0:0] c_st_present = 1'b1;

  // Returns {illegal, nibble} for one active-low digit pattern.
  function automatic logic [4:0] decode_digit(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h40:   res = {1'b0, 4'h0};
      7'h79:   res = {1'b0, 4'h1};
      7'h24:   res = {1'b0, 4'h2};
      7'h30:   res = {1'b0, 4'h3};
      7'h19:   res = {1'b0, 4'h4};
      7'h12:   res = {1'b0, 4'h5};
      7'h02:   res = {1'b0, 4'h6};
      7'h78:   res = {1'b0, 4'h7};
      7'h00:   res = {1'b0, 4'h8};
      7'h10:   res = {1'b0, 4'h9};
      7'h7F:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'hE};
    endcase
    return res;
  endfunction

  logic [13:0]     w_pattern;
  logic            w_match;
  logic [c_cw-1:0] w_count_next;
  logic            w_stable;
  logic            w_new;
  logic [4:0]      w_dec_lo;
  logic [4:0]      w_dec_hi;

  logic [13:0]     r_shadow;
  logic [c_cw-1:0] r_count;
  logic [13:0]     r_last;
  logic            r_first;
  logic [0:0]      r_state;
  logic [0:0]      w_state_next;

  logic            w_load;
  logic            w_clear;
  logic            w_ovr_set;

  assign w_pattern = {seg1, seg0};
  assign w_match   = (w_pattern == r_shadow);

  always_comb begin
    w_count_next = '0;
    if (w_match) begin
      w_count_next = (r_count == c_stable) ? r_count : r_count + 4'd1;
    end
  end

  // Stability is judged on the count this edge will produce, so a pattern is
  // acted on in the same edge that completes its stable period.
  assign w_stable = w_match && (w_count_next == c_stable);
  assign w_new    = w_stable && (r_first || (w_pattern != r_last));

  assign w_dec_lo = decode_digit(seg0);
  assign w_dec_hi = decode_digit(seg1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_count  <= '0;
    end else begin
      if (!w_match) begin
        r_shadow <= w_pattern;
      end
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_wait;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_wait:    if (w_new) w_state_next = c_st_present;
      c_st_present: if (ack)   w_state_next = c_st_wait;
      default:      w_state_next = c_st_wait;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_clear   = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      c_st_wait:    w_load = w_new;
      c_st_present: begin
        w_clear   = ack;
        w_ovr_set = !ack && w_new;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      overrun <= 1'b0;
      r_last  <= '0;
      r_first <= 1'b1;
    end else begin
      if (w_load) begin
        q       <= {w_dec_hi[3:0], w_dec_lo[3:0]};
        err     <= w_dec_hi[4] | w_dec_lo[4];
        valid   <= 1'b1;
        r_last  <= w_pattern;
        r_first <= 1'b0;
      end
      if (w_clear) begin
        valid   <= 1'b0;
        err     <= 1'b0;
        overrun <= 1'b0;
      end else if (w_ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_reader.sv
// ============================================================================
// Module   : tb_seg7_reader
// Purpose  : Directed and randomized checks of seg7_reader against a
//            sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_reader;

  localparam int STABLE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic [7:0] q;
  logic       valid;
  logic       err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [13:0] hist[$];
  logic        m_present;
  logic        m_first;
  logic [13:0] m_last;
  logic [7:0]  m_q;
  logic        m_valid;
  logic        m_err;
  logic        m_ovr;

  seg7_reader #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk(clk), .rst(rst), .seg0(seg0), .seg1(seg1), .ack(ack),
    .q(q), .valid(valid), .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_digit(input logic [6:0] p);
    case (p)
      7'h40: return 5'h00;
      7'h79: return 5'h01;
      7'h24: return 5'h02;
      7'h30: return 5'h03;
      7'h19: return 5'h04;
      7'h12: return 5'h05;
      7'h02: return 5'h06;
      7'h78: return 5'h07;
      7'h00: return 5'h08;
      7'h10: return 5'h09;
      7'h7F: return 5'h0F;
      default: return 5'h1E;
    endcase
  endfunction

  // The reset shadow value behaves like one sample of all-zero taken before
  // the first edge.
  task automatic model_reset();
    hist.delete();
    hist.push_back(14'h0);
    m_present = 1'b0;
    m_first   = 1'b1;
    m_last    = '0;
    m_q       = '0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_ovr     = 1'b0;
  endtask

  function automatic logic ref_stable();
    if (hist.size() != STABLE_CYCLES + 1) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic [13:0] pat, input logic a);
    logic       fresh;
    logic [4:0] hi;
    logic [4:0] lo;
    hist.push_back(pat);
    if (hist.size() > STABLE_CYCLES + 1) void'(hist.pop_front());
    fresh = ref_stable() && (m_first || pat != m_last);
    if (m_present) begin
      if (a) begin
        m_present = 1'b0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_ovr     = 1'b0;
      end else if (fresh) begin
        m_ovr = 1'b1;
      end
    end else if (fresh) begin
      hi        = ref_digit(pat[13:7]);
      lo        = ref_digit(pat[6:0]);
      m_present = 1'b1;
      m_valid   = 1'b1;
      m_q       = {hi[3:0], lo[3:0]};
      m_err     = hi[4] | lo[4];
      m_last    = pat;
      m_first   = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {7'b0, obs}, {7'b0, exp});
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, q, m_q);
    chk1({tag, ".valid"}, valid, m_valid);
    chk1({tag, ".err"}, err, m_err);
    chk1({tag, ".overrun"}, overrun, m_ovr);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge({seg1, seg0}, ack);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic ack_pulse(input string tag);
    ack = 1'b1;
    step(tag);
    ack = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    step({tag, ".hold"});
    rst = 1'b0;
  endtask

  logic [13:0] pool [6] = '{14'h1802, 14'h1840, 14'h0000, 14'h3FD5, 14'h2079, 14'h3FFF};

  initial begin
    int hold_left;
    logic [13:0] pat;

    rst  = 1'b1;
    ack  = 1'b0;
    seg1 = 7'h30;
    seg0 = 7'h02;
    model_reset();
    #2;
    check_all("reset");
    chk("reset.q_const", q, 8'h00);
    step("reset.hold");
    step("reset.hold");
    rst = 1'b0;

    // Held 30/02 from release: presented after the fifth edge.
    steps(4, "hold36.wait");
    chk1("hold36.not_yet", valid, 1'b0);
    step("hold36.present");
    chk("hold36.q", q, 8'h36);
    chk1("hold36.valid", valid, 1'b1);
    chk1("hold36.err", err, 1'b0);
    steps(3, "hold36.frozen");
    chk("hold36.q_frozen", q, 8'h36);
    ack_pulse("hold36.ack");
    chk1("hold36.valid_after_ack", valid, 1'b0);
    step("hold36.no_repeat");
    chk1("hold36.no_repeat_v", valid, 1'b0);

    // Bouncing digit never settles, then settles on 79.
    for (int i = 0; i <= 8; i++) begin
      seg0 = (i % 2 == 0) ? 7'h40 : 7'h79;
      steps(2, "bounce");
      chk1("bounce.valid", valid, 1'b0);
    end
    seg0 = 7'h79;
    steps(4, "settle.wait");
    chk1("settle.not_yet", valid, 1'b0);
    step("settle.present");
    chk1("settle.valid", valid, 1'b1);
    chk("settle.q", q, 8'h31);
    ack_pulse("settle.ack");

    // Blank high digit, illegal low digit.
    seg1 = 7'h7F;
    seg0 = 7'h55;
    steps(5, "illegal");
    chk("illegal.q", q, 8'hFE);
    chk1("illegal.err", err, 1'b1);
    chk1("illegal.valid", valid, 1'b1);
    ack_pulse("illegal.ack");

    // Overrun while presenting, then the missed pattern follows the ack.
    seg1 = 7'h30;
    seg0 = 7'h02;
    steps(5, "ovr.first");
    chk("ovr.first_q", q, 8'h36);
    seg1 = 7'h00;
    seg0 = 7'h00;
    steps(6, "ovr.missed");
    chk1("ovr.flag", overrun, 1'b1);
    chk("ovr.q_held", q, 8'h36);
    ack_pulse("ovr.ack");
    chk1("ovr.valid_drop", valid, 1'b0);
    chk1("ovr.flag_clear", overrun, 1'b0);
    chk("ovr.q_keeps", q, 8'h36);
    step("ovr.next");
    chk1("ovr.next_valid", valid, 1'b1);
    chk("ovr.next_q", q, 8'h88);
    chk1("ovr.next_ovr", overrun, 1'b0);
    ack_pulse("ovr.next_ack");

    // A one-cycle glitch back to the reported pattern is not re-presented.
    seg0 = 7'h79;
    step("glitch.on");
    seg0 = 7'h00;
    steps(8, "glitch.off");
    chk1("glitch.valid", valid, 1'b0);

    // Reset while presenting.
    seg1 = 7'h30;
    seg0 = 7'h02;
    steps(5, "rstmid.present");
    chk1("rstmid.valid_before", valid, 1'b1);
    do_reset("rstmid");
    chk1("rstmid.valid_zero", valid, 1'b0);
    steps(4, "rstmid.wait");
    chk1("rstmid.not_yet", valid, 1'b0);
    step("rstmid.represent");
    chk1("rstmid.valid", valid, 1'b1);
    chk("rstmid.q", q, 8'h36);
    ack_pulse("rstmid.ack");

    // New pattern becomes stable exactly on the ack edge.
    seg0 = 7'h40;
    steps(5, "coin.first");
    chk("coin.first_q", q, 8'h30);
    seg0 = 7'h79;
    steps(4, "coin.count");
    ack_pulse("coin.ack");
    chk1("coin.valid_low", valid, 1'b0);
    chk1("coin.ovr_low", overrun, 1'b0);
    step("coin.next");
    chk1("coin.next_valid", valid, 1'b1);
    chk("coin.next_q", q, 8'h31);
    ack_pulse("coin.next_ack");

    // Randomized traffic over a small pattern pool so repeats are frequent.
    hold_left = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset("rand.rst");
      end else begin
        if (hold_left == 0) begin
          pat       = pool[$urandom_range(0, 5)];
          seg1      = pat[13:7];
          seg0      = pat[6:0];
          hold_left = $urandom_range(1, 9);
        end
        hold_left--;
        ack = ($urandom_range(0, 4) == 0);
        step("rand");
      end
    end
    ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
